// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
package bcd_sched_pkg;

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    localparam int ADD3_THRESH = 5;
    localparam int ADD3_VAL    = 3;

    // Four bits per decimal digit of the largest operand, 2^data_w - 1.
    function automatic int bcd_width(input int data_w);
        longint unsigned max_v;
        int digits;
        max_v  = (64'd1 << data_w) - 64'd1;
        digits = 1;
        while (max_v >= 64'd10) begin
            max_v  = max_v / 64'd10;
            digits = digits + 1;
        end
        return 4 * digits;
    endfunction

endpackage

// File: rtl/bcd_dd_engine.sv
// Iterative double-dabble datapath: load an operand, then one add-3/shift per step.
module bcd_dd_engine
    import bcd_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BCD_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] operand,
    input  logic              step,
    output logic [BCD_W-1:0]  bcd_next
);

    localparam int NUM_DIG = BCD_W / 4;

    logic [DATA_W-1:0]       bin;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        adj;
    logic [BCD_W+DATA_W-1:0] shifted;

    // Nibbles are corrected independently; no carry crosses a digit boundary.
    for (genvar d = 0; d < NUM_DIG; d++) begin : g_dig
        assign adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'(ADD3_THRESH)) ?
                               bcd[d*4 +: 4] + 4'(ADD3_VAL) : bcd[d*4 +: 4];
    end

    assign shifted  = {adj, bin} << 1;
    assign bcd_next = shifted[BCD_W+DATA_W-1 -: BCD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin <= '0;
            bcd <= '0;
        end else if (load) begin
            bin <= operand;
            bcd <= '0;
        end else if (step) begin
            bcd <= shifted[BCD_W+DATA_W-1 -: BCD_W];
            bin <= shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin front end sharing one double-dabble engine between NUM_REQ requesters.
module bcd_convert_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int BCD_W   = bcd_width(DATA_W),
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [BCD_W-1:0]          rsp_bcd,
    output logic [ID_W-1:0]           rsp_id,
    input  logic                      rsp_ready,
    output logic                      busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] operand;
    logic [BCD_W-1:0]  bcd_next;
    logic              load;
    int                idx;

    // Walk downward so the closest valid requester at or after rr_ptr wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                grant_idx = ID_W'(idx);
                grant_any = 1'b1;
            end
        end
    end

    // Gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_any)
            req_ready[grant_idx] = 1'b1;
    end

    assign load    = (state == IDLE) && grant_any;
    assign operand = req_data[grant_idx*DATA_W +: DATA_W];
    assign busy    = (state != IDLE);

    bcd_dd_engine #(
        .DATA_W (DATA_W),
        .BCD_W  (BCD_W)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .operand  (operand),
        .step     (state == CONV),
        .bcd_next (bcd_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_bcd   <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner <= grant_idx;
                        cnt   <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        rsp_bcd   <= bcd_next;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Randomized self-checking bench for bcd_convert_scheduler against a decimal-digit model.
module tb_bcd_convert_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int BCD_W   = 12;
    localparam int ID_W    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        req_valid = '0;
    logic [31:0]       req_data;
    logic [3:0]        req_ready;
    logic              rsp_valid;
    logic [11:0]       rsp_bcd;
    logic [1:0]        rsp_id;
    logic              rsp_ready = 1'b0;
    logic              busy;
    logic [7:0]        dat [4];

    int n_tests = 0;
    int n_fail  = 0;
    int mdl_ptr = 0;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    bcd_convert_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .BCD_W   (BCD_W),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_bcd   (rsp_bcd),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits by division, one per nibble.
    function automatic logic [11:0] bcd_ref(input int v);
        logic [11:0] r;
        r = '0;
        for (int d = 0; d < 3; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int arb(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++)
            if (m[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v == (4'b0001 << i)) return i;
        return -1;
    endfunction

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic serve(input logic [3:0] mask, input int delay, input bit drop,
                         input bit early, output int g_obs, output int waited,
                         output logic [11:0] bcd_obs);
        int          g_exp;
        int          lat;
        logic [11:0] exp_bcd;
        logic [11:0] b0;
        logic [1:0]  id0;
        bit          stable;
        g_obs   = -1;
        waited  = 0;
        bcd_obs = '0;
        req_valid = mask;
        #1;
        while (req_ready == 4'b0 && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (req_ready == 4'b0) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        g_exp   = arb(mask, mdl_ptr);
        g_obs   = onehot_idx(req_ready);
        exp_bcd = bcd_ref(int'(dat[g_exp]));
        chk("req_ready", req_ready, 32'(4'b0001 << g_exp));
        @(negedge clk);
        if (drop)  req_valid = '0;
        if (early) rsp_ready = 1'b1;
        #1;
        chk("conv_busy", busy, 1);
        chk("conv_ready", req_ready, 0);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, DATA_W + 1);
        if (!rsp_valid) return;
        chk("rsp_bcd", rsp_bcd, exp_bcd);
        chk("rsp_id", rsp_id, g_exp);
        bcd_obs = rsp_bcd;
        b0      = rsp_bcd;
        id0     = rsp_id;
        stable  = 1'b1;
        repeat (delay) begin
            @(negedge clk);
            if (!rsp_valid || rsp_bcd !== b0 || rsp_id !== id0 || !busy || req_ready != 4'b0)
                stable = 1'b0;
        end
        if (delay > 0) chk("hold", stable, 1);
        rsp_ready = 1'b1;
        #1;
        chk("bubble", req_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
        mdl_ptr = (g_exp + 1) % 4;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        int          w;
        int          r;
        int          cnt;
        bit          quiet;
        logic [11:0] b;
        logic [3:0]  m;
        bit          e;
        int          sweep_v [6]   = '{0, 9, 10, 99, 128, 200};
        logic [11:0] sweep_e [6]   = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h128, 12'h200};
        int          rr_g    [5]   = '{0, 1, 2, 3, 0};
        logic [11:0] rr_b    [5]   = '{12'h011, 12'h022, 12'h033, 12'h044, 12'h011};

        dat = '{default: 8'd0};
        dat[0]    = 8'd255;
        req_valid = 4'b0001;
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_bcd", rsp_bcd, 0);
        chk("rst_rsp_id", rsp_id, 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;

        serve(4'b0001, 0, 1'b1, 1'b0, g, w, b);
        chk("first_grant", g, 0);
        chk("first_bcd", b, 12'h255);

        for (int i = 0; i < 6; i++) begin
            dat[2] = 8'(sweep_v[i]);
            serve(4'b0100, 0, 1'b1, 1'b0, g, w, b);
            chk("sweep2_id", g, 2);
            chk("sweep2_bcd", b, sweep_e[i]);
        end

        // rr_ptr moves to 1, then only requester 3 is valid.
        dat[0] = 8'd5;
        serve(4'b0001, 0, 1'b1, 1'b0, g, w, b);
        dat[3] = 8'd7;
        serve(4'b1000, 0, 1'b1, 1'b0, g, w, b);
        chk("skip_grant", g, 3);

        dat[0] = 8'd11; dat[1] = 8'd22; dat[2] = 8'd33; dat[3] = 8'd44;
        for (int i = 0; i < 5; i++) begin
            serve(4'b1111, 0, 1'b0, 1'b0, g, w, b);
            chk("rr_grant", g, rr_g[i]);
            chk("rr_bcd", b, rr_b[i]);
        end
        req_valid = '0;

        dat[0] = 8'd50; dat[1] = 8'd61;
        serve(4'b0011, 20, 1'b0, 1'b0, g, w, b);
        chk("bp_grant", g, 1);
        chk("bp_bcd", b, 12'h061);
        serve(4'b0011, 0, 1'b1, 1'b0, g, w, b);
        chk("bp_next_wait", w, 0);
        chk("bp_next_grant", g, 0);

        for (int v = 0; v < 256; v++) begin
            r      = int'($urandom_range(0, 3));
            dat[r] = 8'(v);
            serve(4'(1 << r), int'($urandom_range(0, 2)), 1'b1, 1'b0, g, w, b);
        end

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 4; j++) dat[j] = 8'($urandom);
            m = 4'($urandom_range(1, 15));
            e = 1'($urandom_range(0, 1));
            serve(m, e ? 0 : int'($urandom_range(0, 4)), 1'b1, e, g, w, b);
        end

        // Leave rr_ptr at 3 so a stale pointer would grant requester 3 below.
        dat[2] = 8'd123;
        serve(4'b0100, 0, 1'b1, 1'b0, g, w, b);
        dat[0]    = 8'd173;
        req_valid = 4'b0001;
        #1;
        cnt = 0;
        while (!req_ready[0] && cnt < 50) begin
            @(negedge clk); #1;
            cnt++;
        end
        chk("mid_accept", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_bcd", rsp_bcd, 0);
        chk("mid_rst_id", rsp_id, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        mdl_ptr = 0;
        quiet   = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) quiet = 1'b0;
        end
        chk("mid_discard", quiet, 1);
        dat[0] = 8'd42;
        dat[3] = 8'd99;
        serve(4'b1001, 0, 1'b1, 1'b0, g, w, b);
        chk("post_rst_grant", g, 0);
        chk("post_rst_bcd", b, 12'h042);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_convert_scheduler.md
Name: bcd_convert_scheduler

Overview:
Shares one iterative double-dabble binary-to-BCD engine between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Sequences the engine for DATA_W shift/add-3 iterations per conversion.
- Returns the result with the winning requester's ID on a single valid/ready response channel.
- Sits between display/telemetry producers and the shared BCD datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, binary operand width.
- BCD_W, 12, result width; must equal 4*ceil(DATA_W*log10(2)).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_W  packed operands; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot acceptance strobe.
- rsp_valid  out  1  result valid.
- rsp_bcd  out  BCD_W  packed BCD result; hundreds digit in the MS nibble.
- rsp_id  out  ID_W  index of the requester that owns rsp_bcd.
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous assert, active-low.
- Reset values:
  - state=IDLE; rr_ptr=0.
  - rsp_valid=0, rsp_bcd=0, rsp_id=0, busy=0.
  - req_ready=0; the iteration counter and engine registers are cleared.
- States:
  - IDLE: wait for any request.
  - CONV: DATA_W engine iterations.
  - RESP: hold the result until the response handshake completes.
- IDLE:
  - If any req_valid is high, grant the first requester at or after rr_ptr (wrapping modulo NUM_REQ).
  - req_ready[g] is combinationally high in that cycle only.
  - On the edge: capture req_data[g] into the engine, latch g, clear the counter, go to CONV.
- req_ready is all-zero in CONV and RESP.
- Requesters must hold req_valid/req_data until ready.
- Dropping req_valid before the grant is legal; no acceptance occurs.
- CONV, each cycle:
  - For every BCD nibble >= 5, add 3.
  - Then shift {bcd, bin} left by one.
  - Increment the counter.
  - After iteration DATA_W-1: load rsp_bcd and rsp_id, set rsp_valid=1, go to RESP.
- Latency: rsp_valid is high exactly DATA_W+1 cycles after the acceptance cycle (9 for the defaults).
- RESP:
  - rsp_valid, rsp_bcd and rsp_id are held stable until rsp_valid && rsp_ready.
  - On the handshake edge: rsp_valid=0, rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
  - One idle bubble is required: no request is accepted in the handshake cycle itself.
- rsp_ready while not in RESP is ignored.
- A requester that deasserts req_valid does not advance rr_ptr.
- Starvation bound: a continuously valid requester is granted within NUM_REQ conversions.
- Arithmetic: the add-3 is 4-bit per nibble, no carry between nibbles. The maximum input 2^DATA_W-1 must not overflow BCD_W.
- rst_n low mid-CONV or mid-RESP: the conversion is aborted, the result is discarded, and all outputs return to reset values asynchronously.

Decomposition:
- Package bcd_sched_pkg:
  - state enum {IDLE, CONV, RESP};
  - function computing BCD_W from DATA_W;
  - ADD3_THRESH=5 and ADD3_VAL=3 constants.
- Sub-module bcd_dd_engine: iterative shift/add-3 datapath with load, step and result outputs, no control state.
- The scheduler holds the FSM, round-robin pointer, iteration counter and response registers.

Test Plan:
- Reset: rst_n=0 -> rsp_valid=0, req_ready=0, busy=0. Release; single req 0 with data 8'd255 -> req_ready=4'b0001 in cycle 0; rsp_bcd=12'h255, rsp_id=0, rsp_valid at cycle 9.
- Value sweep from requester 2: 0->12'h000, 9->12'h009, 10->12'h010, 99->12'h099, 128->12'h128, 200->12'h200; rsp_id=2 each time. Full 0..255 sweep compared against a model.
- Round-robin: all four requesters valid continuously with data 11,22,33,44 -> grants in order 0,1,2,3,0; responses 12'h011, 12'h022, 12'h033, 12'h044.
- Backpressure: hold rsp_ready=0 for 20 cycles -> rsp_* stable, busy=1, req_ready stays 0; the response completes when rsp_ready=1. A new request pending during the handshake is accepted the following cycle (one bubble).
- Reset mid-op: assert rst_n=0 at iteration 4 with 8'd173 -> outputs clear immediately. After release, a request with 8'd42 -> 12'h042 with rr_ptr restarted at 0.
- Pointer skip: rr_ptr=1 with only requester 3 valid -> requester 3 is granted; the next grant searches from 0.
